// File: rtl/solver_arb_pkg.sv
// Shared types and constants for the solver arbiter slice.
package solver_arb_pkg;

    // Operand / result widths of the shared expression_solver.
    localparam int unsigned X_W = 8;
    localparam int unsigned D_W = 16;

    // Default configuration.
    localparam int unsigned DEF_N       = 4;
    localparam int unsigned DEF_TIMEOUT = 64;

    // Job sequencing states.
    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StReply
    } arb_state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after ptr, wrapping modulo N.
module rr_arbiter
    import solver_arb_pkg::*;
#(
    parameter int unsigned N  = DEF_N,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          valid,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] cand;

    // Scan N candidates starting from ptr; the first hit wins.
    always_comb begin
        valid = 1'b0;
        grant = '0;
        idx   = '0;
        cand  = '0;
        for (int unsigned k = 0; k < N; k++) begin
            cand = IW'((32'(ptr) + k) % N);
            if (!valid && req[cand]) begin
                valid       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/solver_arbiter.sv
// Shares one expression_solver among N requesters: round-robin grant, operand issue,
// completion wait with watchdog, and a one-cycle response pulse to the granted requester.
module solver_arbiter
    import solver_arb_pkg::*;
#(
    parameter int unsigned N       = DEF_N,
    parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic [N*X_W-1:0] req_x,
    input  logic [N*D_W-1:0] req_a,
    input  logic [N*D_W-1:0] req_b,
    input  logic [N*D_W-1:0] req_c,
    output logic [N-1:0]     ack,
    output logic [N-1:0]     done,
    output logic [D_W-1:0]   resp_result,
    output logic             resp_zero,
    output logic             resp_overflow,
    output logic             resp_err,
    output logic             slv_start,
    output logic [X_W-1:0]   slv_x,
    output logic [D_W-1:0]   slv_a,
    output logic [D_W-1:0]   slv_b,
    output logic [D_W-1:0]   slv_c,
    input  logic [D_W-1:0]   slv_result,
    input  logic             slv_zero,
    input  logic             slv_overflow,
    input  logic             slv_completed
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned CW = $clog2(TIMEOUT + 1);

    arb_state_e     state_q, state_d;
    logic [IW-1:0]  ptr_q, ptr_d;
    logic [IW-1:0]  cur_q, cur_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [N-1:0]   ack_q, ack_d;
    logic [N-1:0]   done_q, done_d;
    logic           start_q, start_d;
    logic [X_W-1:0] x_q, x_d;
    logic [D_W-1:0] a_q, a_d, b_q, b_d, c_q, c_d;
    logic [D_W-1:0] result_q, result_d;
    logic           zero_q, zero_d, ovf_q, ovf_d, err_q, err_d;

    logic           gnt_valid;
    logic [N-1:0]   gnt_onehot;
    logic [IW-1:0]  gnt_idx;

    rr_arbiter #(
        .N  (N),
        .IW (IW)
    ) u_rr (
        .req   (req),
        .ptr   (ptr_q),
        .valid (gnt_valid),
        .grant (gnt_onehot),
        .idx   (gnt_idx)
    );

    // Next-state and next-output logic; every output is registered.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cur_d    = cur_q;
        cnt_d    = cnt_q;
        ack_d    = '0;
        done_d   = '0;
        start_d  = 1'b0;
        x_d      = x_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        result_d = result_q;
        zero_d   = zero_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (gnt_valid) begin
                    cur_d   = gnt_idx;
                    x_d     = req_x[gnt_idx*X_W +: X_W];
                    a_d     = req_a[gnt_idx*D_W +: D_W];
                    b_d     = req_b[gnt_idx*D_W +: D_W];
                    c_d     = req_c[gnt_idx*D_W +: D_W];
                    ack_d   = gnt_onehot;
                    start_d = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                ptr_d   = (cur_q == IW'(N - 1)) ? '0 : cur_q + 1'b1;
                cnt_d   = '0;
                state_d = StWait;
            end
            StWait: begin
                cnt_d = cnt_q + 1'b1;
                // cnt_q == 0 is the first WAIT cycle: a stale completed flag is ignored there.
                if (cnt_q != '0 && slv_completed) begin
                    result_d      = slv_result;
                    zero_d        = slv_zero;
                    ovf_d         = slv_overflow;
                    err_d         = 1'b0;
                    done_d[cur_q] = 1'b1;
                    state_d       = StReply;
                end else if (cnt_q == CW'(TIMEOUT)) begin
                    result_d      = '0;
                    zero_d        = 1'b0;
                    ovf_d         = 1'b0;
                    err_d         = 1'b1;
                    done_d[cur_q] = 1'b1;
                    state_d       = StReply;
                end
            end
            StReply: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and output registers; reset abandons any job in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= StIdle;
            ptr_q    <= '0;
            cur_q    <= '0;
            cnt_q    <= '0;
            ack_q    <= '0;
            done_q   <= '0;
            start_q  <= 1'b0;
            x_q      <= '0;
            a_q      <= '0;
            b_q      <= '0;
            c_q      <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            cur_q    <= cur_d;
            cnt_q    <= cnt_d;
            ack_q    <= ack_d;
            done_q   <= done_d;
            start_q  <= start_d;
            x_q      <= x_d;
            a_q      <= a_d;
            b_q      <= b_d;
            c_q      <= c_d;
            result_q <= result_d;
            zero_q   <= zero_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
        end
    end

    assign ack           = ack_q;
    assign done          = done_q;
    assign slv_start     = start_q;
    assign slv_x         = x_q;
    assign slv_a         = a_q;
    assign slv_b         = b_q;
    assign slv_c         = c_q;
    assign resp_result   = result_q;
    assign resp_zero     = zero_q;
    assign resp_overflow = ovf_q;
    assign resp_err      = err_q;

endmodule
